run_sequencer: RTL

Host-side run sequencer for the matrix-multiplication processor. Sits directly upstream of the control unit and drives its 2-bit `status` start input. Consumes the control unit's registered `end_process` flag to close each run. Also gates the UART instruction/data loader, counts run cycles and flags runs that never finish.

---
 rtl/run_seq_pkg.sv | 18 +
 rtl/rise_detect.sv | 18 +
 rtl/run_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared status codes and state enumeration for the run sequencer.
package run_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b10;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Single-flop rising-edge detector: pulse when the input is 1 now and was 0 last cycle.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= in_i;
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/run_sequencer.sv
// Host-side run sequencer: load/run/ack handshake, run-cycle counter and timeout.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_req,
    input  logic             load_done,
    input  logic             start_req,
    input  logic             ack_req,
    input  logic             end_process,
    output logic [1:0]       status,
    output logic             load_en,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             loaded_q;
    logic             load_ev, start_ev, ack_ev;

    rise_detect u_rd_load  (.clk(clk), .rst_n(rst_n), .in_i(load_req),  .rise_o(load_ev));
    rise_detect u_rd_start (.clk(clk), .rst_n(rst_n), .in_i(start_req), .rise_o(start_ev));
    rise_detect u_rd_ack   (.clk(clk), .rst_n(rst_n), .in_i(ack_req),   .rise_o(ack_ev));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_ev) state_d = S_LOAD;
            S_LOAD:  if (load_done) state_d = S_READY;
            S_READY: begin
                if (load_ev)                    state_d = S_LOAD;
                else if (start_ev && loaded_q)  state_d = S_RUN;
            end
            // Completion beats timeout when both occur on the same edge.
            S_RUN: begin
                if (end_process)            state_d = S_DONE;
                else if (count_q == TMO_LAST) state_d = S_ERROR;
            end
            S_DONE: begin
                if (ack_ev)       state_d = S_READY;
                else if (load_ev) state_d = S_LOAD;
            end
            S_ERROR: if (ack_ev) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;

            // Counter keeps running on the exit edge so DONE/ERROR show the full run length.
            if (state_q != S_RUN && state_d == S_RUN) count_q <= '0;
            else if (state_q == S_RUN)                count_q <= count_q + CNT_W'(1);

            if (state_d != state_q && (state_d == S_LOAD || state_d == S_ERROR))
                loaded_q <= 1'b0;
            else if (load_done)
                loaded_q <= 1'b1;
        end
    end

    always_comb begin
        status  = ST_IDLE;
        load_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        error   = 1'b0;
        case (state_q)
            S_LOAD:  begin status = ST_LOAD; load_en = 1'b1; busy = 1'b1; end
            S_RUN:   begin status = ST_RUN;  busy = 1'b1; end
            S_DONE:  begin status = ST_FIN;  done = 1'b1; end
            S_ERROR: begin status = ST_FIN;  error = 1'b1; end
            default: status = ST_IDLE;
        endcase
    end

    assign cycle_count = count_q;

endmodule
